// File: rtl/qrd_pkg.sv
// qrd_pkg: shared types and default sizing for the QRD-RLS feed sequencer
package qrd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   localparam int QRD_DATA_LENGTH = 8;
   localparam int QRD_N_CH = 5;
   localparam int QRD_ARRAY_LATENCY = 12;
   localparam int QRD_CNT_W = 16;
   function automatic int flush_len(input int n_ch, input int latency);
      return n_ch - 1 + latency;
   endfunction
endpackage

// File: rtl/qrd_skew_line.sv
// qrd_skew_line: DEPTH-stage delay line carrying one lane word plus its valid tag
//   d/tag     : lane word and tag entering this cycle
//   q/tag_out : the same word and tag, DEPTH cycles later
module qrd_skew_line #(
   parameter int DEPTH = 1,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   input  logic         tag,
   output logic [W-1:0] q,
   output logic         tag_out
);
   logic [DEPTH-1:0][W-1:0] data_q, data_d;
   logic [DEPTH-1:0]        tag_q, tag_d;
   if (DEPTH == 1) begin : g_one
      always_comb begin
         data_d = d;
         tag_d = tag;
      end
   end else begin : g_many
      always_comb begin
         data_d = {data_q[DEPTH-2:0], d};
         tag_d = {tag_q[DEPTH-2:0], tag};
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         tag_q <= '0;
      end else begin
         data_q <= data_d;
         tag_q <= tag_d;
      end
   end
   assign q = data_q[DEPTH-1];
   assign tag_out = tag_q[DEPTH-1];
endmodule

// File: rtl/qrd_feed_sequencer.sv
// qrd_feed_sequencer: feeds skewed sample vectors into the QRD-RLS systolic array
//   start/stop/cfg_num_samples : burst control (limit 0 = run until stop)
//   s_valid/s_ready/s_x/s_sk   : upstream sample handshake
//   arr_x/arr_sk/arr_ready_in  : skewed lanes and lane-0 valid tag to the array
//   out_valid                  : array error/wxout belongs to an accepted sample
//   busy/done/accepted_cnt     : status
module qrd_feed_sequencer
   import qrd_pkg::*;
#(
   parameter int DATA_LENGTH = QRD_DATA_LENGTH,
   parameter int N_CH = QRD_N_CH,
   parameter int ARRAY_LATENCY = QRD_ARRAY_LATENCY,
   parameter int CNT_W = QRD_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic [CNT_W-1:0]            cfg_num_samples,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [N_CH*DATA_LENGTH-1:0] s_x,
   input  logic [DATA_LENGTH-1:0]      s_sk,
   output logic [N_CH*DATA_LENGTH-1:0] arr_x,
   output logic [DATA_LENGTH-1:0]      arr_sk,
   output logic                        arr_ready_in,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        done,
   output logic [CNT_W-1:0]            accepted_cnt
);
   localparam int FLUSH_LEN = flush_len(N_CH, ARRAY_LATENCY);
   localparam int FW = $clog2(FLUSH_LEN);
   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            lim_q, lim_d, cnt_q, cnt_d;
   logic [FW-1:0]               fl_q, fl_d;
   logic [ARRAY_LATENCY-1:0]    ov_q, ov_d;
   logic [DATA_LENGTH-1:0]      sk_q, sk_d;
   logic [N_CH*DATA_LENGTH-1:0] lane_in;
   logic [N_CH-1:0]             tag_out;
   logic                        acc;
   logic                        unused_tags;
   always_comb begin
      state_d = state_q;
      lim_d = lim_q;
      cnt_d = cnt_q;
      fl_d = fl_q;
      acc = (state_q == RUN) && s_valid;
      if (state_q == IDLE && start) begin
         state_d = RUN;
         lim_d = cfg_num_samples;
         cnt_d = '0;
         fl_d = '0;
      end
      if (acc) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      // the accept that reaches the limit is still counted before leaving RUN
      if (state_q == RUN && (stop || (acc && lim_q != '0 && cnt_d == lim_q))) state_d = FLUSH;
      if (state_q == FLUSH) begin
         fl_d = fl_q + 1'b1;
         if (fl_q == FW'(FLUSH_LEN - 1)) state_d = DONE;
      end
      if (state_q == DONE) state_d = IDLE;
      // bubbles enter the array as all-zero words with a cleared tag
      lane_in = acc ? s_x : '0;
      sk_d = acc ? s_sk : '0;
      ov_d = {ov_q[ARRAY_LATENCY-2:0], tag_out[0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lim_q <= '0;
         cnt_q <= '0;
         fl_q <= '0;
         ov_q <= '0;
         sk_q <= '0;
      end else begin
         state_q <= state_d;
         lim_q <= lim_d;
         cnt_q <= cnt_d;
         fl_q <= fl_d;
         ov_q <= ov_d;
         sk_q <= sk_d;
      end
   end
   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      qrd_skew_line #(.DEPTH(k + 1), .W(DATA_LENGTH)) u_skew (
         .clk     (clk),
         .rst     (rst),
         .d       (lane_in[k*DATA_LENGTH +: DATA_LENGTH]),
         .tag     (acc),
         .q       (arr_x[k*DATA_LENGTH +: DATA_LENGTH]),
         .tag_out (tag_out[k])
      );
   end
   // only lane 0's tag drives the array; the deeper lane tags ride along unused
   assign unused_tags = ^tag_out;
   assign s_ready = state_q == RUN;
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign accepted_cnt = cnt_q;
   assign arr_sk = sk_q;
   assign arr_ready_in = tag_out[0];
   assign out_valid = ov_q[ARRAY_LATENCY-1];
endmodule

// File: tb/tb_qrd_feed_sequencer.sv
// tb_qrd_feed_sequencer: table-driven and scoreboard checks of the feed sequencer
module tb_qrd_feed_sequencer;
   localparam int NC = 5;
   localparam int LAT = 12;
   logic clk = 0, rst = 1, start = 0, stop = 0, s_valid = 0;
   logic [15:0] cfg = '0;
   logic [39:0] s_x = '0;
   logic [7:0] s_sk = '0;
   logic s_ready, arr_ready_in, out_valid, busy, done;
   logic [39:0] arr_x;
   logic [7:0] arr_sk;
   logic [15:0] accepted_cnt;
   logic s_ready4, arr_ready_in4, out_valid4, busy4, done4;
   logic [39:0] arr_x4;
   logic [7:0] arr_sk4;
   logic [3:0] accepted_cnt4;
   int cyc = 0, checks = 0, failures = 0, n = 0, done_cyc = -1;
   typedef struct {int t; logic [7:0] d;} ent_t;
   ent_t lq[NC][$];
   ent_t skq[$];
   int ovq[$];
   typedef struct {bit st, sv, stp, rdy, bsy, ex; int cnt; logic [15:0] c; int w;} vec_t;
   vec_t tab[19];
   logic [39:0] mx;
   logic [7:0] msk;
   logic mrdy, mov, mdone;

   qrd_feed_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_num_samples(cfg),
      .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_sk(s_sk),
      .arr_x(arr_x), .arr_sk(arr_sk), .arr_ready_in(arr_ready_in), .out_valid(out_valid),
      .busy(busy), .done(done), .accepted_cnt(accepted_cnt)
   );
   qrd_feed_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_num_samples(cfg[3:0]),
      .s_valid(s_valid), .s_ready(s_ready4), .s_x(s_x), .s_sk(s_sk),
      .arr_x(arr_x4), .arr_sk(arr_sk4), .arr_ready_in(arr_ready_in4), .out_valid(out_valid4),
      .busy(busy4), .done(done4), .accepted_cnt(accepted_cnt4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
      end
   endtask

   function automatic logic [39:0] lanes(input int s);
      logic [39:0] v;
      for (int k = 0; k < NC; k++) v[k*8 +: 8] = 8'(8'h11 * (k + 1) + s);
      return v;
   endfunction

   task automatic drive(input bit r, st, sv, stp, acc, ex, input logic [15:0] c);
      @(posedge clk);
      #1;
      rst = r; start = st; stop = stp; s_valid = sv; cfg = c;
      s_x = sv ? lanes(n) : 40'({$urandom(), $urandom()});
      s_sk = sv ? 8'(8'hA0 + n) : 8'($urandom());
      if (acc) begin
         for (int k = 0; k < NC; k++) lq[k].push_back('{cyc + 1 + k, s_x[k*8 +: 8]});
         skq.push_back('{cyc + 1, s_sk});
         ovq.push_back(cyc + 1 + LAT);
         n++;
      end
      if (ex) done_cyc = cyc + NC + LAT;
      if (r) begin
         for (int k = 0; k < NC; k++) while (lq[k].size() > 0 && lq[k][$].t > cyc) void'(lq[k].pop_back());
         while (skq.size() > 0 && skq[$].t > cyc) void'(skq.pop_back());
         while (ovq.size() > 0 && ovq[$] > cyc) void'(ovq.pop_back());
         done_cyc = -1;
      end
   endtask

   task automatic idle(input int k);
      repeat (k) drive(0, 0, 0, 0, 0, 0, 16'd0);
   endtask

   task automatic chk_zero(input string p);
      chk({p, ".s_ready"}, s_ready, 0);
      chk({p, ".arr_x"}, arr_x, 0);
      chk({p, ".arr_sk"}, arr_sk, 0);
      chk({p, ".arr_ready_in"}, arr_ready_in, 0);
      chk({p, ".out_valid"}, out_valid, 0);
      chk({p, ".busy"}, busy, 0);
      chk({p, ".done"}, done, 0);
      chk({p, ".accepted_cnt"}, accepted_cnt, 0);
   endtask

   always @(negedge clk) begin
      mx = '0; msk = '0; mrdy = 0;
      for (int k = 0; k < NC; k++)
         if (lq[k].size() > 0 && lq[k][0].t == cyc) begin
            mx[k*8 +: 8] = lq[k][0].d;
            if (k == 0) mrdy = 1;
            void'(lq[k].pop_front());
         end
      if (skq.size() > 0 && skq[0].t == cyc) begin
         msk = skq[0].d;
         void'(skq.pop_front());
      end
      mov = ovq.size() > 0 && ovq[0] == cyc;
      if (mov) void'(ovq.pop_front());
      mdone = cyc == done_cyc;
      chk("arr_x", arr_x, mx);
      chk("arr_sk", arr_sk, msk);
      chk("arr_ready_in", arr_ready_in, mrdy);
      chk("out_valid", out_valid, mov);
      chk("done", done, mdone);
      chk("arr_x.w4", arr_x4, mx);
      chk("arr_ready_in.w4", arr_ready_in4, mrdy);
      chk("out_valid.w4", out_valid4, mov);
      chk("done.w4", done4, mdone);
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      //         st sv stp rdy bsy ex cnt cfg    wait
      tab = '{
         '{1, 0, 0, 0, 0, 0, 0, 16'd3, 0},
         '{0, 1, 0, 1, 1, 0, 0, 16'd3, 0},
         '{0, 1, 0, 1, 1, 0, 1, 16'd3, 0},
         '{0, 1, 0, 1, 1, 1, 2, 16'd3, 0},
         '{0, 1, 0, 0, 1, 0, 3, 16'd3, 0},
         '{1, 1, 0, 0, 1, 0, 3, 16'd3, 20},
         '{1, 0, 0, 0, 0, 0, 3, 16'd4, 0},
         '{0, 1, 0, 1, 1, 0, 0, 16'd4, 0},
         '{0, 0, 0, 1, 1, 0, 1, 16'd4, 0},
         '{0, 1, 0, 1, 1, 0, 1, 16'd4, 0},
         '{0, 1, 0, 1, 1, 0, 2, 16'd4, 0},
         '{0, 1, 0, 1, 1, 1, 3, 16'd4, 0},
         '{1, 0, 0, 0, 1, 0, 4, 16'd4, 20},
         '{1, 0, 0, 0, 0, 0, 4, 16'd0, 0},
         '{1, 1, 0, 1, 1, 0, 0, 16'd0, 0},
         '{0, 1, 1, 1, 1, 1, 1, 16'd0, 0},
         '{0, 1, 0, 0, 1, 0, 2, 16'd0, 20},
         '{0, 0, 1, 0, 0, 0, 2, 16'd0, 0},
         '{0, 1, 0, 0, 0, 0, 2, 16'd0, 0}
      };
      drive(1, 0, 0, 0, 0, 0, 16'd0);
      drive(0, 0, 0, 0, 0, 0, 16'd0);
      chk_zero("reset");
      foreach (tab[i]) begin
         drive(0, tab[i].st, tab[i].sv, tab[i].stp, tab[i].sv && tab[i].rdy, tab[i].ex, tab[i].c);
         chk("tab.s_ready", s_ready, tab[i].rdy);
         chk("tab.busy", busy, tab[i].bsy);
         chk("tab.accepted_cnt", accepted_cnt, 64'(tab[i].cnt));
         idle(tab[i].w);
      end
      drive(0, 0, 0, 0, 0, 0, 16'd0);
      chk("ignored_stop.busy", busy, 0);
      drive(0, 1, 0, 0, 0, 0, 16'd0);
      drive(0, 0, 1, 0, 1, 0, 16'd0);
      drive(0, 0, 1, 0, 1, 0, 16'd0);
      drive(1, 0, 1, 0, 0, 0, 16'd0);
      chk("prerst.accepted_cnt", accepted_cnt, 2);
      drive(0, 0, 0, 0, 0, 0, 16'd0);
      chk_zero("midrst");
      idle(20);
      drive(0, 1, 0, 0, 0, 0, 16'd0);
      repeat (20) drive(0, 0, 1, 0, 1, 0, 16'd0);
      drive(0, 0, 0, 1, 0, 1, 16'd0);
      drive(0, 0, 0, 0, 0, 0, 16'd0);
      chk("sat.accepted_cnt4", accepted_cnt4, 15);
      chk("sat.accepted_cnt", accepted_cnt, 20);
      chk("sat.busy4", busy4, 1);
      idle(20);
      chk("sat.end_busy4", busy4, 0);
      chk("sat.end_cnt4", accepted_cnt4, 15);
      chk("sb_empty", 64'(lq[0].size() + lq[NC-1].size() + skq.size() + ovq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
